dma_timing_and_control: RTL

- Per-transfer timing and control state machine of the KF8237 DMA controller.
- Arbitrates channel requests (fixed priority) and runs the HRQ/HLDA bus handshake.
- Sequences the 8237 S0–S4 transfer states and drives the memory/IO strobes.
- Directly upstream of the address-and-count register block: supplies transfer_register_select, next_word and initialize_current_register, and consumes its underflow flag to detect terminal count.

---
 rtl/dma_timing_and_control_if.sv | 49 ++++
 rtl/dma_timing_and_control.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dma_timing_and_control_if.sv
`default_nettype none
// ============================================================================
// Module  : dma_timing_and_control_if
// Brief   : Request, handshake and bus-strobe bundle of the DMA timing block.
// Rev     : 1.0  initial release
// ============================================================================
interface dma_timing_and_control_if;
  logic [3:0] dma_request;
  logic       hold_acknowledge;
  logic       end_of_process_n;
  logic       underflow;
  logic [1:0] transfer_mode;
  logic [1:0] transfer_type;
  logic       autoinitialize;
  logic       status_clear;
  logic       master_clear;
  logic       hold_request;
  logic [3:0] dma_acknowledge;
  logic [3:0] transfer_register_select;
  logic       next_word;
  logic       initialize_current_register;
  logic       end_of_process;
  logic [3:0] terminal_count;
  logic       address_enable;
  logic       address_strobe;
  logic       memory_read_n;
  logic       memory_write_n;
  logic       io_read_n;
  logic       io_write_n;

  modport master (
    input  dma_request, hold_acknowledge, end_of_process_n, underflow,
           transfer_mode, transfer_type, autoinitialize, status_clear, master_clear,
    output hold_request, dma_acknowledge, transfer_register_select, next_word,
           initialize_current_register, end_of_process, terminal_count,
           address_enable, address_strobe, memory_read_n, memory_write_n,
           io_read_n, io_write_n
  );

  modport slave (
    output dma_request, hold_acknowledge, end_of_process_n, underflow,
           transfer_mode, transfer_type, autoinitialize, status_clear, master_clear,
    input  hold_request, dma_acknowledge, transfer_register_select, next_word,
           initialize_current_register, end_of_process, terminal_count,
           address_enable, address_strobe, memory_read_n, memory_write_n,
           io_read_n, io_write_n
  );
endinterface
`default_nettype wire

// File: rtl/dma_timing_and_control.sv
`default_nettype none
// ============================================================================
// Module  : dma_timing_and_control
// Brief   : KF8237 transfer sequencer: fixed-priority grant, HRQ/HLDA, S0-S4.
// Rev     : 1.0  initial release
// ============================================================================
module dma_timing_and_control (
  input  wire logic                clock,
  input  wire logic                reset,
  dma_timing_and_control_if.master bus
);
  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_S0   = 3'd1;
  localparam logic [2:0] c_S1   = 3'd2;
  localparam logic [2:0] c_S2   = 3'd3;
  localparam logic [2:0] c_S3   = 3'd4;
  localparam logic [2:0] c_S4   = 3'd5;
  localparam logic [2:0] c_SA   = 3'd6;

  localparam logic [1:0] c_MODE_DEMAND = 2'b00;
  localparam logic [1:0] c_MODE_BLOCK  = 2'b10;
  localparam logic [1:0] c_TYPE_WRITE  = 2'b01;
  localparam logic [1:0] c_TYPE_READ   = 2'b10;

  logic [2:0] r_state;
  logic [3:0] r_select;
  logic       r_eop_seen;
  logic       r_hold_request;
  logic [3:0] r_dack;
  logic       r_next_word;
  logic       r_init;
  logic       r_eop;
  logic [3:0] r_tc;
  logic       r_aen;
  logic       r_adstb;
  logic       r_mem_rd_n;
  logic       r_mem_wr_n;
  logic       r_io_rd_n;
  logic       r_io_wr_n;

  logic [2:0] w_next_state;
  logic [3:0] w_grant;
  logic       w_req_held;
  logic       w_eop_now;
  logic [3:0] w_select;
  logic       w_hold_request;
  logic       w_aen;
  logic [3:0] w_dack;
  logic       w_adstb;
  logic       w_next_word;
  logic       w_init;
  logic       w_eop;
  logic [3:0] w_tc;
  logic       w_rd_phase;
  logic       w_mem_rd_n;
  logic       w_mem_wr_n;
  logic       w_io_rd_n;
  logic       w_io_wr_n;

  always_comb begin
    w_grant = 4'b0000;
    if      (bus.dma_request[0]) w_grant = 4'b0001;
    else if (bus.dma_request[1]) w_grant = 4'b0010;
    else if (bus.dma_request[2]) w_grant = 4'b0100;
    else if (bus.dma_request[3]) w_grant = 4'b1000;
  end

  assign w_req_held = |(bus.dma_request & r_select);
  assign w_eop_now  = bus.underflow | r_eop_seen | ~bus.end_of_process_n;

  // State and every output are registered together; outputs decode the next state.
  always_ff @(posedge clock) begin
    if (!reset || bus.master_clear) begin
      r_state        <= c_IDLE;
      r_select       <= 4'b0000;
      r_eop_seen     <= 1'b0;
      r_hold_request <= 1'b0;
      r_dack         <= 4'b0000;
      r_next_word    <= 1'b0;
      r_init         <= 1'b0;
      r_eop          <= 1'b0;
      r_tc           <= 4'b0000;
      r_aen          <= 1'b0;
      r_adstb        <= 1'b0;
      r_mem_rd_n     <= 1'b1;
      r_mem_wr_n     <= 1'b1;
      r_io_rd_n      <= 1'b1;
      r_io_wr_n      <= 1'b1;
    end else begin
      r_state        <= w_next_state;
      r_select       <= w_select;
      r_hold_request <= w_hold_request;
      r_dack         <= w_dack;
      r_next_word    <= w_next_word;
      r_init         <= w_init;
      r_eop          <= w_eop;
      r_tc           <= w_tc;
      r_aen          <= w_aen;
      r_adstb        <= w_adstb;
      r_mem_rd_n     <= w_mem_rd_n;
      r_mem_wr_n     <= w_mem_wr_n;
      r_io_rd_n      <= w_io_rd_n;
      r_io_wr_n      <= w_io_wr_n;
      if (w_next_state == c_S1)
        r_eop_seen <= 1'b0;
      else if ((r_state == c_S2 || r_state == c_S3) && !bus.end_of_process_n)
        r_eop_seen <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: if (bus.dma_request != 4'b0000) w_next_state = c_S0;
      c_S0: begin
        if (bus.hold_acknowledge) w_next_state = c_S1;
        else if (!w_req_held)     w_next_state = c_IDLE;
      end
      c_S1: w_next_state = c_S2;
      c_S2: w_next_state = c_S3;
      c_S3: w_next_state = c_S4;
      c_S4: begin
        if (w_eop_now)
          w_next_state = bus.autoinitialize ? c_SA : c_IDLE;
        else if (bus.transfer_mode == c_MODE_BLOCK)
          w_next_state = c_S1;
        else if (bus.transfer_mode == c_MODE_DEMAND && w_req_held)
          w_next_state = c_S1;
        else
          w_next_state = c_IDLE;
      end
      c_SA:    w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    w_select = r_select;
    if (w_next_state == c_IDLE)  w_select = 4'b0000;
    else if (r_state == c_IDLE)  w_select = w_grant;

    w_hold_request = (w_next_state != c_IDLE);
    w_aen          = w_next_state inside {c_S1, c_S2, c_S3, c_S4, c_SA};
    w_dack         = w_aen ? w_select : 4'b0000;
    w_adstb        = (w_next_state == c_S1);
    w_next_word    = (w_next_state == c_S3);
    w_init         = (w_next_state == c_SA);
    w_rd_phase     = (w_next_state == c_S2) || (w_next_state == c_S3);

    w_mem_rd_n = !(w_rd_phase && bus.transfer_type == c_TYPE_READ);
    w_io_rd_n  = !(w_rd_phase && bus.transfer_type == c_TYPE_WRITE);
    w_io_wr_n  = !(w_next_state == c_S3 && bus.transfer_type == c_TYPE_READ);
    w_mem_wr_n = !(w_next_state == c_S3 && bus.transfer_type == c_TYPE_WRITE);

    w_eop = (r_state == c_S4) && w_eop_now;

    // A terminal-count set wins over a coincident status read.
    w_tc = r_tc;
    if (r_state == c_S4 && bus.underflow) w_tc = r_tc | r_select;
    else if (bus.status_clear)            w_tc = 4'b0000;
  end

  assign bus.hold_request                = r_hold_request;
  assign bus.dma_acknowledge             = r_dack;
  assign bus.transfer_register_select    = r_select;
  assign bus.next_word                   = r_next_word;
  assign bus.initialize_current_register = r_init;
  assign bus.end_of_process              = r_eop;
  assign bus.terminal_count              = r_tc;
  assign bus.address_enable              = r_aen;
  assign bus.address_strobe              = r_adstb;
  assign bus.memory_read_n               = r_mem_rd_n;
  assign bus.memory_write_n              = r_mem_wr_n;
  assign bus.io_read_n                   = r_io_rd_n;
  assign bus.io_write_n                  = r_io_wr_n;
endmodule
`default_nettype wire
